// File: rtl/heading_pkg.sv
// Shared types and constants for the ship heading unit: widths, FSM states and the
// quarter-wave angle folding used for both the sin and cos lookups.
package heading_pkg;

   localparam int ANGLE_W    = 9;
   localparam int TRIG_W     = 18;
   localparam logic signed [TRIG_W-1:0] TRIG_ONE = 18'sd131071;
   localparam int QROM_DEPTH = 91;

   typedef enum logic [2:0] {IDLE, FETCH_S, WAIT_S, FETCH_C, WAIT_C, COMMIT} hdg_state_t;

   // Folds a 0..359 degree angle onto the 0..90 quarter table; returns {rom_addr, negate}.
   function automatic logic [7:0] quad_map(input logic [ANGLE_W-1:0] a);
      logic [6:0] idx;
      logic       neg;
      if (a <= 9'd90) begin
         idx = 7'(a);
         neg = 1'b0;
      end else if (a <= 9'd180) begin
         idx = 7'(9'd180 - a);
         neg = 1'b0;
      end else if (a <= 9'd270) begin
         idx = 7'(a - 9'd180);
         neg = 1'b1;
      end else begin
         idx = 7'(9'd360 - a);
         neg = 1'b1;
      end
      return {idx, neg};
   endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table, 91 x 17-bit magnitudes round(sin(i deg) * 131071),
// registered read with one cycle of latency.
module quarter_sine_rom
   import heading_pkg::*;
(
   input  logic        clk,
   input  logic [6:0]  address,
   output logic [16:0] q
);

   localparam int SIN_TBL [QROM_DEPTH] = '{
           0,   2288,   4574,   6860,   9143,  11424,  13701,  15974,  18242,  20504,
       22760,  25010,  27251,  29485,  31709,  33924,  36128,  38321,  40503,  42673,
       44829,  46972,  49100,  51214,  53311,  55393,  57458,  59505,  61534,  63544,
       65536,  67507,  69457,  71386,  73294,  75179,  77042,  78880,  80695,  82486,
       84251,  85990,  87704,  89390,  91050,  92681,  94285,  95859,  97405,  98921,
      100406, 101861, 103285, 104678, 106039, 107367, 108663, 109925, 111155, 112350,
      113511, 114637, 115729, 116785, 117806, 118791, 119739, 120651, 121527, 122365,
      123166, 123930, 124656, 125344, 125994, 126605, 127178, 127712, 128207, 128663,
      129080, 129457, 129795, 130094, 130353, 130572, 130752, 130891, 130991, 131051,
      131071
   };

   always_ff @(posedge clk)
      q <= (address < 7'(QROM_DEPTH)) ? 17'(SIN_TBL[address]) : '0;

endmodule

// File: rtl/ship_heading_unit.sv
// Ship heading register stepped once per frame, with sin/cos looked up from a quarter-wave ROM.
// Optional ROT_ACCEL_EN: step doubles after ACCEL_FRAMES consecutive same-direction steps.
module ship_heading_unit
   import heading_pkg::*;
#(
   parameter int ANGLES       = 360,
   parameter int ROT_STEP     = 3,
   parameter int ACCEL_FRAMES = 4
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              vsync,
   input  logic              rot_left,
   input  logic              rot_right,
   output logic [ANGLE_W-1:0] angle,
   output logic [TRIG_W-1:0]  sin_val,
   output logic [TRIG_W-1:0]  cos_val,
   output logic              hdg_valid,
   output logic              busy
);

   // Sized for the doubled step so both builds share one datapath width.
   localparam int MAX_STEP = (ACCEL_FRAMES > 0) ? 2 * ROT_STEP : ROT_STEP;
   localparam int STEP_W   = $clog2(MAX_STEP + 1);

   hdg_state_t         r_state, w_state_nx;
   logic               r_go;
   logic [ANGLE_W-1:0] r_next;
   logic [TRIG_W-1:0]  r_sin_new, r_cos_new;
   logic [STEP_W-1:0]  w_step;
   logic [ANGLE_W:0]   w_sum, w_dif, w_cos_arg;
   logic [ANGLE_W-1:0] w_stepped, w_cos_ang;
   logic [7:0]         w_map_s, w_map_c;
   logic [6:0]         w_rom_addr;
   logic [16:0]        w_rom_q;
   logic [TRIG_W-1:0]  w_mag;
   logic               w_dir, w_sample, w_cap_s, w_cap_c, w_commit;

   assign w_dir    = rot_left ^ rot_right;
   assign w_sample = vsync && (r_state == IDLE) && !r_go;

`ifdef ROT_ACCEL_EN
   localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);
   logic [HOLD_W-1:0] r_hold;
   logic              r_hold_left;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hold      <= '0;
         r_hold_left <= 1'b0;
      end else if (!w_dir) begin
         r_hold <= '0;
      end else if (w_sample) begin
         r_hold_left <= rot_left;
         if (r_hold == '0 || rot_left != r_hold_left) r_hold <= HOLD_W'(1);
         else if (r_hold != HOLD_W'(ACCEL_FRAMES))    r_hold <= r_hold + 1'b1;
      end
   end

   assign w_step = (r_hold >= HOLD_W'(ACCEL_FRAMES)) ? STEP_W'(2 * ROT_STEP) : STEP_W'(ROT_STEP);
`else
   assign w_step = STEP_W'(ROT_STEP);
`endif

   // One correction of ANGLES is enough because the step never reaches a full turn.
   assign w_sum = {1'b0, angle} + 10'(w_step);
   assign w_dif = {1'b0, angle} - 10'(w_step);

   always_comb begin
      if (rot_left)
         w_stepped = (w_sum >= 10'(ANGLES)) ? ANGLE_W'(w_sum - 10'(ANGLES)) : ANGLE_W'(w_sum);
      else
         w_stepped = w_dif[ANGLE_W] ? ANGLE_W'(w_dif + 10'(ANGLES)) : ANGLE_W'(w_dif);
   end

   assign w_cos_arg = {1'b0, r_next} + 10'd90;
   assign w_cos_ang = (w_cos_arg >= 10'd360) ? ANGLE_W'(w_cos_arg - 10'd360) : ANGLE_W'(w_cos_arg);
   assign w_map_s   = quad_map(r_next);
   assign w_map_c   = quad_map(w_cos_ang);
   assign w_mag     = {1'b0, w_rom_q};

   quarter_sine_rom u_rom (
      .clk     (clk),
      .address (w_rom_addr),
      .q       (w_rom_q)
   );

   always_comb begin
      w_state_nx = r_state;
      w_rom_addr = w_map_s[7:1];
      w_cap_s    = 1'b0;
      w_cap_c    = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         IDLE:    if (r_go) w_state_nx = FETCH_S;
         FETCH_S: w_state_nx = WAIT_S;
         WAIT_S:  begin w_cap_s = 1'b1; w_state_nx = FETCH_C; end
         FETCH_C: begin w_rom_addr = w_map_c[7:1]; w_state_nx = WAIT_C; end
         WAIT_C:  begin w_cap_c = 1'b1; w_state_nx = COMMIT; end
         COMMIT:  begin w_commit = 1'b1; w_state_nx = IDLE; end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= IDLE;
      else         r_state <= w_state_nx;
   end

   // The vsync edge only latches the target; the lookup starts on the following edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_go      <= 1'b0;
         r_next    <= '0;
         r_sin_new <= '0;
         r_cos_new <= '0;
         angle     <= '0;
         sin_val   <= '0;
         cos_val   <= TRIG_ONE;
         hdg_valid <= 1'b0;
      end else begin
         r_go      <= w_sample && w_dir;
         hdg_valid <= w_commit;
         if (w_sample && w_dir) r_next    <= w_stepped;
         if (w_cap_s)           r_sin_new <= w_map_s[0] ? -w_mag : w_mag;
         if (w_cap_c)           r_cos_new <= w_map_c[0] ? -w_mag : w_mag;
         if (w_commit) begin
            angle   <= r_next;
            sin_val <= r_sin_new;
            cos_val <= r_cos_new;
         end
      end
   end

   assign busy = (r_state != IDLE);

endmodule
